// File: rtl/morse_keyer.sv
// Morse keyer: synchronizes and debounces a raw key, classifies each press
// as a dot or a dash, and builds a heap-tree letter index. The index is
// committed after a long enough released gap.
module morse_keyer #(
   parameter int unsigned DEBOUNCE_CYC = 250000,
   parameter int unsigned DOT_MAX_CYC  = 10000000,
   parameter int unsigned GAP_CYC      = 30000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key,
   input  logic       clear,
   output logic [5:0] morse_code,
   output logic       code_valid,
   output logic [2:0] sym_count,
   output logic       busy,
   output logic       overflow
);

   localparam int unsigned DbW    = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned PressW = $clog2(DOT_MAX_CYC + 1);
   localparam int unsigned GapW   = $clog2(GAP_CYC + 1);

   typedef enum logic [1:0] {StIdle, StPress, StGap, StCommit} state_t;

   logic [1:0]        sync_q;
   logic [DbW-1:0]    db_cnt_q, db_cnt_d;
   logic              key_db_q, key_db_d;
   logic              key_db_prev_q;
   logic              rise, fall, is_dot;

   state_t            state_q, state_d;
   logic [5:0]        acc_q, acc_d;
   logic [2:0]        sym_q, sym_d;
   logic              err_q, err_d;
   logic [PressW-1:0] press_q, press_d;
   logic [GapW-1:0]   gap_q, gap_d;
   logic              pend_q, pend_d;
   logic [5:0]        code_q, code_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;

   // Input synchronizer, debounced level and its one-cycle-delayed copy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q        <= '0;
         db_cnt_q      <= '0;
         key_db_q      <= 1'b0;
         key_db_prev_q <= 1'b0;
      end else begin
         sync_q        <= {sync_q[0], key};
         db_cnt_q      <= db_cnt_d;
         key_db_q      <= key_db_d;
         key_db_prev_q <= key_db_q;
      end
   end

   // Debouncer: accept a new level after DEBOUNCE_CYC consecutive differing cycles
   always_comb begin
      db_cnt_d = '0;
      key_db_d = key_db_q;
      if (sync_q[1] != key_db_q) begin
         if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
            key_db_d = sync_q[1];
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   assign rise   = key_db_q & ~key_db_prev_q;
   assign fall   = ~key_db_q & key_db_prev_q;
   assign is_dot = press_q < PressW'(DOT_MAX_CYC);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath update; clear overrides everything
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sym_d   = sym_q;
      err_d   = err_q;
      press_d = press_q;
      gap_d   = gap_q;
      pend_d  = pend_q;
      code_d  = code_q;
      valid_d = 1'b0;
      ovf_d   = ovf_q;
      if (clear) begin
         state_d = StIdle;
         acc_d   = '0;
         sym_d   = '0;
         err_d   = 1'b0;
         press_d = '0;
         gap_d   = '0;
         pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // pend_q carries a rising edge that arrived while committing
               if (rise || pend_q) begin
                  state_d = StPress;
                  press_d = '0;
                  pend_d  = 1'b0;
               end
            end
            StPress: begin
               if (press_q != PressW'(DOT_MAX_CYC)) begin
                  press_d = press_q + 1'b1;
               end
               if (fall) begin
                  state_d = StGap;
                  gap_d   = '0;
                  if (sym_q == 3'd5) begin
                     err_d = 1'b1;
                  end else begin
                     sym_d = sym_q + 3'd1;
                     acc_d = {acc_q[4:0], 1'b0} + (is_dot ? 6'd1 : 6'd2);
                  end
               end
            end
            StGap: begin
               if (gap_q == GapW'(GAP_CYC - 1)) begin
                  state_d = StCommit;
                  if (rise) begin
                     pend_d = 1'b1;
                  end
               end else if (rise) begin
                  state_d = StPress;
                  press_d = '0;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            StCommit: begin
               code_d  = err_q ? 6'd0 : acc_q;
               valid_d = 1'b1;
               if (err_q) begin
                  ovf_d = 1'b1;
               end
               acc_d   = '0;
               sym_d   = '0;
               err_d   = 1'b0;
               state_d = StIdle;
               if (rise) begin
                  pend_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         sym_q   <= '0;
         err_q   <= 1'b0;
         press_q <= '0;
         gap_q   <= '0;
         pend_q  <= 1'b0;
         code_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         sym_q   <= sym_d;
         err_q   <= err_d;
         press_q <= press_d;
         gap_q   <= gap_d;
         pend_q  <= pend_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign morse_code = code_q;
   assign code_valid = valid_q;
   assign sym_count  = sym_q;
   assign busy       = (state_q != StIdle);
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer with short timing parameters.
module tb_morse_keyer;

   logic       clk;
   logic       rst_n;
   logic       key;
   logic       clear;
   logic [5:0] morse_code;
   logic       code_valid;
   logic [2:0] sym_count;
   logic       busy;
   logic       overflow;

   typedef struct packed {
      logic [5:0] code;
      logic       ovf;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   morse_keyer #(
      .DEBOUNCE_CYC(4),
      .DOT_MAX_CYC (20),
      .GAP_CYC     (50)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key       (key),
      .clear     (clear),
      .morse_code(morse_code),
      .code_valid(code_valid),
      .sym_count (sym_count),
      .busy      (busy),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then step just past the edge to drive inputs
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int n);
      key = 1'b1;
      cyc(n);
      key = 1'b0;
   endtask

   task automatic push(input logic [5:0] code, input logic ovf);
      exp_t e;
      e.code = code;
      e.ovf  = ovf;
      sb.push_back(e);
   endtask

   // Wait (bounded) for the letter to finish, then let the pulse drain
   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check(tag, int'(busy), 0);
      cyc(3);
   endtask

   // Scoreboard monitor: every code_valid pulse consumes one expected letter
   always @(negedge clk) begin
      if (rst_n && code_valid) begin
         if (sb.size() == 0) begin
            check("spurious_valid", int'(code_valid), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("code", int'(morse_code), int'(e.code));
            check("overflow", int'(overflow), int'(e.ovf));
         end
      end
   end

   initial begin
      int lat;
      logic busy_seen;
      rst_n = 1'b0;
      key   = 1'b0;
      clear = 1'b0;
      cyc(3);
      @(negedge clk);
      check("rst_code", int'(morse_code), 0);
      check("rst_valid", int'(code_valid), 0);
      check("rst_sym", int'(sym_count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ovf", int'(overflow), 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(5);

      // Single dot; latency from key release to the pulse
      push(6'd1, 1'b0);
      press(10);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         lat++;
         if (code_valid) break;
      end
      check("dot_latency", lat, 59);
      cyc(5);

      // Letter A: dot then dash
      push(6'd4, 1'b0);
      press(10);
      cyc(10);
      @(negedge clk);
      check("a_sym1", int'(sym_count), 1);
      cyc(1);
      press(30);
      cyc(10);
      @(negedge clk);
      check("a_sym2", int'(sym_count), 2);
      wait_idle("a_idle");
      check("a_sym0", int'(sym_count), 0);

      // Six dots overflow the letter and blank the display
      push(6'd0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         press(10);
         cyc(10);
      end
      @(negedge clk);
      check("ovf_sym5", int'(sym_count), 5);
      wait_idle("ovf_idle");
      check("ovf_sticky", int'(overflow), 1);

      // Single dash after overflow; flag stays set
      push(6'd2, 1'b1);
      press(30);
      wait_idle("t_idle");

      // Bounce never survives the debouncer
      busy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         key = ~key;
         cyc(2);
         busy_seen |= busy;
      end
      key = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         busy_seen |= busy;
      end
      check("bounce_busy", int'(busy_seen), 0);
      check("bounce_code", int'(morse_code), 2);
      cyc(1);

      // Letter E to set a known display value
      push(6'd1, 1'b1);
      press(10);
      wait_idle("e_idle");

      // Clear after two symbols aborts the letter
      press(10);
      cyc(10);
      press(10);
      cyc(10);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      @(negedge clk);
      check("clr_busy", int'(busy), 0);
      check("clr_sym", int'(sym_count), 0);
      check("clr_code", int'(morse_code), 1);
      cyc(80);
      push(6'd2, 1'b1);
      press(30);
      wait_idle("clr_t_idle");

      // Clear while held: release must not start a letter
      key = 1'b1;
      cyc(15);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      cyc(10);
      key = 1'b0;
      cyc(20);
      @(negedge clk);
      check("clr_held_busy", int'(busy), 0);
      cyc(60);

      // Reset pulse during a press discards the letter
      key = 1'b1;
      cyc(12);
      @(negedge clk);
      check("pre_rst_busy", int'(busy), 1);
      cyc(1);
      rst_n = 1'b0;
      key   = 1'b0;
      #1;
      check("arst_code", int'(morse_code), 0);
      check("arst_valid", int'(code_valid), 0);
      check("arst_sym", int'(sym_count), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_ovf", int'(overflow), 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(100);

      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
